// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch bus between the IF stage and the memory
interface if_stage_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   modport master (output imem_addr, imem_req, input imem_rdata, imem_valid);
   modport slave (input imem_addr, imem_req, output imem_rdata, imem_valid);
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one-entry skid buffer feeding the IF/ID register
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcnoch,
   input  logic        ifidnoch,
   input  logic        flush,
   input  logic [31:0] br_target,
   if_stage_if.master  imem,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        fetch_stall,
   output logic [15:0] bubble_cnt
);
   typedef enum logic {FETCH, HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
   logic        ifid_valid_q, ifid_valid_d, bubble;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   assign imem.imem_addr = pc_q;
   assign imem.imem_req  = state_q == FETCH && !rst;
   assign fetch_stall    = state_q == FETCH && !imem.imem_valid;
   assign ifid_pc        = ifid_pc_q;
   assign ifid_instr     = ifid_instr_q;
   assign ifid_valid     = ifid_valid_q;
   assign bubble_cnt     = bubble_cnt_q;
   // next state: flush beats hazard holds, which beat normal advance
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      bubble       = 1'b0;
      if (flush) begin
         pc_d         = br_target;
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         state_d      = FETCH;
         bubble       = 1'b1;
      end else if (state_q == FETCH) begin
         if (imem.imem_valid && !ifidnoch) begin
            ifid_instr_d = imem.imem_rdata;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = pcnoch ? pc_q : pc_q + 32'd4;
         end else if (imem.imem_valid) begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
         end else if (!ifidnoch) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            bubble       = 1'b1;
         end
      end else if (!ifidnoch) begin
         ifid_instr_d = skid_instr_q;
         ifid_pc_d    = skid_pc_q;
         ifid_valid_d = 1'b1;
         pc_d         = pcnoch ? pc_q : pc_q + 32'd4;
         state_d      = FETCH;
      end
      bubble_cnt_d = (bubble && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
   end
   // state registers; reset overrides every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pcnoch  input  1  hazard-unit request to hold PC.
REQ-006 SHALL have port ifidnoch  input  1  hazard-unit request to hold IF/ID register.
REQ-007 SHALL have port flush  input  1  taken branch/jump resolved in EX; redirect fetch.
REQ-008 SHALL have port br_target  input  32  redirect address, valid while flush=1.
REQ-009 SHALL have port imem_addr  output  32  fetch address, combinationally equal to pc.
REQ-010 SHALL have port imem_req  output  1  fetch request; high only in state FETCH with rst=0.
REQ-011 SHALL have port imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-012 SHALL have port imem_valid  input  1  memory returns instruction this cycle; latency 0..N cycles.
REQ-013 SHALL have port ifid_pc  output  32  registered PC of instruction in IF/ID.
REQ-014 SHALL have port ifid_instr  output  32  registered instruction in IF/ID.
REQ-015 SHALL have port ifid_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-016 SHALL have port fetch_stall  output  1  combinational; high in FETCH while imem_valid=0.
REQ-017 SHALL have port bubble_cnt  output  16  count of cycles ifid_valid was loaded with 0.

Function
REQ-018 SHALL implement two states: FETCH (request outstanding) and HOLD (fetched word parked in skid buffer).
REQ-019 SHALL apply priority per cycle: rst > flush > ifidnoch/pcnoch hold > normal advance.
REQ-020 SHALL, on flush in any state: pc<=br_target, ifid_instr<=NOP_INSTR, ifid_valid<=0, skid buffer discarded, state<=FETCH, regardless of pcnoch/ifidnoch.
REQ-021 SHALL, in FETCH with imem_valid=1 and ifidnoch=0: ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1, pc<=pc+4.
REQ-022 SHALL, in FETCH with imem_valid=1 and ifidnoch=1: store imem_rdata and pc in skid buffer, hold IF/ID and pc, state<=HOLD.
REQ-023 SHALL, in FETCH with imem_valid=0 and ifidnoch=0: ifid_instr<=NOP_INSTR, ifid_valid<=0, pc unchanged.
REQ-024 SHALL hold IF/ID unchanged whenever ifidnoch=1 and flush=0.
REQ-025 SHALL never advance pc while pcnoch=1 (flush excepted); pc advances only when an instruction enters IF/ID.
REQ-026 SHALL, in HOLD with ifidnoch=0: load IF/ID from skid buffer (ifid_valid<=1), pc<=pc+4 if pcnoch=0, state<=FETCH; imem_req=0 throughout HOLD.
REQ-027 SHALL, in HOLD with pcnoch=1 and ifidnoch=0, still drain the buffer but leave pc unchanged, re-fetching the same address next cycle.
REQ-028 SHALL compute pc+4 modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-029 SHALL increment bubble_cnt on every cycle where ifid_valid is loaded with 0 (REQ-020, REQ-023), saturating at 16'hFFFF.

Reset
REQ-030 SHALL on rst=1 at posedge clk set pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, bubble_cnt=0, skid buffer empty, state=FETCH, overriding all other inputs including flush.
REQ-031 SHALL abandon any in-flight fetch when rst asserts mid-operation; a late imem_valid in the reset cycle is ignored.

Verification
REQ-032 Reset then imem_valid=1 every cycle with rdata=0xA0,0xA1,0xA2 -> ifid_pc 0,4,8 with matching instr, ifid_valid=1, bubble_cnt=0.
REQ-033 pcnoch=ifidnoch=1 for one cycle while imem_valid=1 at pc=8 -> state HOLD, IF/ID frozen, next cycle ifid_pc=8 from buffer, pc=0xC.
REQ-034 imem_valid=0 for 3 cycles at pc=0x10 -> fetch_stall=1, three NOP bubbles with ifid_valid=0, bubble_cnt=3, imem_addr=0x10 held.
REQ-035 flush=1, br_target=0x200 while in HOLD with ifidnoch=1 -> buffer discarded, ifid_valid=0, next imem_addr=0x200.
REQ-036 rst=1 in same cycle as flush=1 and imem_valid=1 -> pc=RESET_PC, all outputs at reset values.
REQ-037 pc=0xFFFFFFFC, imem_valid=1 -> ifid_pc=0xFFFFFFFC, pc wraps to 0x00000000.
